// File: rtl/fifo_nibble_packer_if.sv
// Purpose: bundles the FIFO read side and the packed-word output side of the nibble packer.
// Ports: master = packer view (drives fifo_rd_en and the output word), slave = environment view.
// Signals: fifo_empty/fifo_rd_data/fifo_rd_en (fall-through FIFO), out_data/out_valid/out_ready/out_partial, words_out.
interface fifo_nibble_packer_if #(
  parameter int NIBBLES = 2
);
  localparam int W = 4 * NIBBLES;

  logic         fifo_empty;
  logic [3:0]   fifo_rd_data;
  logic         fifo_rd_en;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_partial;
  logic [7:0]   words_out;

  modport master (
    input  fifo_empty, fifo_rd_data, out_ready,
    output fifo_rd_en, out_data, out_valid, out_partial, words_out
  );

  modport slave (
    output fifo_empty, fifo_rd_data, out_ready,
    input  fifo_rd_en, out_data, out_valid, out_partial, words_out
  );
endinterface

// File: rtl/fifo_nibble_packer.sv
// Purpose: pops 4-bit nibbles from a fall-through FIFO and packs NIBBLES of them into one registered word.
// Latency: last nibble popped in cycle t -> out_valid in t+1; one word per NIBBLES cycles when unblocked.
// Backpressure: fifo_rd_en is withheld only for the word-completing pop while the output word is unaccepted.
// Ports: clk, rstN (async active-low), bus (fifo_nibble_packer_if.master).
// Optional: define PACKER_FLUSH_TIMEOUT_EN to flush a zero-padded partial word after TIMEOUT idle cycles.
module fifo_nibble_packer #(
  parameter int NIBBLES   = 2,
  parameter bit LSB_FIRST = 1'b1,
  parameter int TIMEOUT   = 16
) (
  input  logic                   clk,
  input  logic                   rstN,
  fifo_nibble_packer_if.master   bus
);

  localparam int W  = 4 * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  if (NIBBLES < 2 || NIBBLES > 8) begin : g_bad_nibbles
    $error("fifo_nibble_packer: NIBBLES must be 2..8");
  end
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("fifo_nibble_packer: TIMEOUT must be 1..255");
  end

  typedef enum logic {IDLE, FILL} state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  nib_cnt;
  logic [W-1:0]   acc;
  logic [W-1:0]   acc_ins;   // accumulator with the current FIFO nibble inserted at its slot
  logic           last;
  logic           stall;
  logic           pop;
  logic           accept;
  logic           flush;

  assign last   = (nib_cnt == CW'(NIBBLES - 1));
  // Only the completing pop needs the output register; earlier pops go into the accumulator.
  assign stall  = last && bus.out_valid && !bus.out_ready;
  assign pop    = !bus.fifo_empty && !stall;
  assign accept = bus.out_valid && bus.out_ready;
  assign bus.fifo_rd_en = pop;

  always_comb begin
    acc_ins = acc;
    for (int i = 0; i < NIBBLES; i++) begin
      if (int'(nib_cnt) == (LSB_FIRST ? i : NIBBLES - 1 - i)) begin
        acc_ins[i*4 +: 4] = bus.fifo_rd_data;
      end
    end
  end

`ifdef PACKER_FLUSH_TIMEOUT_EN
  logic [7:0] idle_cnt;
  logic       out_free;
  logic       partial_q;

  // Output register can take the partial word if empty or being drained this cycle.
  assign out_free = !bus.out_valid || bus.out_ready;
  assign flush    = (state == FILL) && !pop && (idle_cnt >= 8'(TIMEOUT)) && out_free;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      idle_cnt <= 8'd0;
    end else if (state == IDLE || pop || flush) begin
      idle_cnt <= 8'd0;
    end else if (bus.fifo_empty && idle_cnt < 8'(TIMEOUT)) begin
      idle_cnt <= idle_cnt + 8'd1;   // saturates at TIMEOUT while waiting for the output
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      partial_q <= 1'b0;
    end else if (pop && last) begin
      partial_q <= 1'b0;
    end else if (flush) begin
      partial_q <= 1'b1;
    end else if (accept) begin
      partial_q <= 1'b0;
    end
  end
  assign bus.out_partial = partial_q;
`else
  assign flush           = 1'b0;
  assign bus.out_partial = 1'b0;
`endif

  // FSM: IDLE means an empty accumulator, FILL means a word is partially built.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (pop && !last) state_nxt = FILL;
      FILL: if ((pop && last) || flush) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Accumulator and slot counter.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      nib_cnt <= '0;
      acc     <= '0;
    end else if (pop) begin
      if (last) begin
        nib_cnt <= '0;
        acc     <= '0;
      end else begin
        nib_cnt <= nib_cnt + CW'(1);
        acc     <= acc_ins;
      end
    end else if (flush) begin
      nib_cnt <= '0;
      acc     <= '0;
    end
  end

  // Output register: a new word may load on the same edge the previous one is accepted.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      bus.out_data  <= '0;
      bus.out_valid <= 1'b0;
    end else if (pop && last) begin
      bus.out_data  <= acc_ins;
      bus.out_valid <= 1'b1;
    end else if (flush) begin
      bus.out_data  <= acc;   // unfilled slots are still zero
      bus.out_valid <= 1'b1;
    end else if (accept) begin
      bus.out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      bus.words_out <= 8'd0;
    end else if (accept) begin
      bus.words_out <= bus.words_out + 8'd1;
    end
  end

endmodule

// File: tb/tb_fifo_nibble_packer.sv
// Purpose: directed testbench for fifo_nibble_packer with NIBBLES=2, one DUT per LSB_FIRST setting.
// Both DUTs share a small fall-through FIFO model; pops follow dut0's fifo_rd_en.
// Optional: define PACKER_FLUSH_TIMEOUT_EN to exercise the partial-word flush.
module tb_fifo_nibble_packer;

  logic       clk = 1'b0;
  logic       rstN = 1'b0;
  logic       out_ready = 1'b0;
  logic [3:0] mem [64];
  logic [5:0] rp = 6'd0;
  logic [5:0] wp = 6'd0;
  logic       fifo_empty;
  int         pop_cnt = 0;
  int         bad_rd = 0;
  int         n_cmp = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  fifo_nibble_packer_if #(.NIBBLES(2)) bus0 ();
  fifo_nibble_packer_if #(.NIBBLES(2)) bus1 ();

  assign fifo_empty        = (rp == wp);
  assign bus0.fifo_empty   = fifo_empty;
  assign bus1.fifo_empty   = fifo_empty;
  assign bus0.fifo_rd_data = mem[rp];
  assign bus1.fifo_rd_data = mem[rp];
  assign bus0.out_ready    = out_ready;
  assign bus1.out_ready    = out_ready;

  fifo_nibble_packer #(.NIBBLES(2), .LSB_FIRST(1'b1), .TIMEOUT(16)) dut0 (
    .clk(clk), .rstN(rstN), .bus(bus0.master));
  fifo_nibble_packer #(.NIBBLES(2), .LSB_FIRST(1'b0), .TIMEOUT(16)) dut1 (
    .clk(clk), .rstN(rstN), .bus(bus1.master));

  always @(posedge clk) begin
    if (bus0.fifo_rd_en && fifo_empty) bad_rd++;
    if (bus0.fifo_rd_en && !fifo_empty) begin
      rp <= rp + 6'd1;
      pop_cnt++;
    end
  end

  task automatic push(input logic [3:0] n);
    mem[wp] = n;
    wp = wp + 6'd1;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    step(2);
    n_cmp++; if (bus0.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus0.out_valid); end
    n_cmp++; if (bus0.out_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", bus0.out_data); end
    n_cmp++; if (bus0.words_out !== 8'd0) begin n_fail++; $display("FAIL reset_words: got %0d want 0", bus0.words_out); end
    n_cmp++; if (bus0.out_partial !== 1'b0) begin n_fail++; $display("FAIL reset_partial: got %b want 0", bus0.out_partial); end
    n_cmp++; if (bus0.fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %b want 0", bus0.fifo_rd_en); end
    rstN = 1'b1;
    step(1);
  endtask

  task automatic test_basic;
    out_ready = 1'b1;
    push(4'h3);
    push(4'hA);
    #1;
    n_cmp++; if (bus0.fifo_rd_en !== 1'b1) begin n_fail++; $display("FAIL basic_rd_en: got %b want 1", bus0.fifo_rd_en); end
    step(1);
    n_cmp++; if (bus0.out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid: got %b want 0", bus0.out_valid); end
    step(1);
    n_cmp++; if (bus0.out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b want 1", bus0.out_valid); end
    n_cmp++; if (bus0.out_data !== 8'hA3) begin n_fail++; $display("FAIL basic_lsb_data: got %h want a3", bus0.out_data); end
    n_cmp++; if (bus1.out_data !== 8'h3A) begin n_fail++; $display("FAIL basic_msb_data: got %h want 3a", bus1.out_data); end
    n_cmp++; if (bus0.fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL basic_rd_en_empty: got %b want 0", bus0.fifo_rd_en); end
    step(1);
    n_cmp++; if (bus0.out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_drop: got %b want 0", bus0.out_valid); end
    n_cmp++; if (bus0.words_out !== 8'd1) begin n_fail++; $display("FAIL basic_words: got %0d want 1", bus0.words_out); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp_lsb [4];
    logic [7:0] exp_msb [4];
    logic [7:0] w0;
    logic       exp_v;
    exp_lsb = '{8'h21, 8'h43, 8'h65, 8'h87};
    exp_msb = '{8'h12, 8'h34, 8'h56, 8'h78};
    w0 = bus0.words_out;
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) push(4'(i));
    #1;
    n_cmp++; if (bus0.fifo_rd_en !== 1'b1) begin n_fail++; $display("FAIL b2b_rd_en_start: got %b want 1", bus0.fifo_rd_en); end
    for (int k = 1; k <= 9; k++) begin
      step(1);
      exp_v = (k % 2 == 0) && (k <= 8);
      n_cmp++; if (bus0.out_valid !== exp_v) begin n_fail++; $display("FAIL b2b_valid[%0d]: got %b want %b", k, bus0.out_valid, exp_v); end
      if (exp_v) begin
        n_cmp++; if (bus0.out_data !== exp_lsb[k/2-1]) begin n_fail++; $display("FAIL b2b_lsb[%0d]: got %h want %h", k, bus0.out_data, exp_lsb[k/2-1]); end
        n_cmp++; if (bus1.out_data !== exp_msb[k/2-1]) begin n_fail++; $display("FAIL b2b_msb[%0d]: got %h want %h", k, bus1.out_data, exp_msb[k/2-1]); end
      end
      n_cmp++; if (bus0.fifo_rd_en !== (k < 8)) begin n_fail++; $display("FAIL b2b_rd_en[%0d]: got %b want %b", k, bus0.fifo_rd_en, (k < 8)); end
    end
    n_cmp++; if (bus0.words_out !== 8'(w0 + 8'd4)) begin n_fail++; $display("FAIL b2b_words: got %0d want %0d", bus0.words_out, 8'(w0 + 8'd4)); end
  endtask

  task automatic test_backpressure;
    logic [7:0] w0;
    int         p0;
    w0 = bus0.words_out;
    p0 = pop_cnt;
    out_ready = 1'b0;
    repeat (6) push(4'h5);
    step(6);
    n_cmp++; if (pop_cnt - p0 !== 3) begin n_fail++; $display("FAIL bp_pops_stalled: got %0d want 3", pop_cnt - p0); end
    n_cmp++; if (bus0.fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL bp_rd_en_stall: got %b want 0", bus0.fifo_rd_en); end
    n_cmp++; if (bus0.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_held: got %b want 1", bus0.out_valid); end
    n_cmp++; if (bus0.out_data !== 8'h55) begin n_fail++; $display("FAIL bp_data_held: got %h want 55", bus0.out_data); end
    out_ready = 1'b1;
    #1;
    n_cmp++; if (bus0.fifo_rd_en !== 1'b1) begin n_fail++; $display("FAIL bp_rd_en_release: got %b want 1", bus0.fifo_rd_en); end
    step(1);
    n_cmp++; if (bus0.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_next_valid: got %b want 1", bus0.out_valid); end
    n_cmp++; if (bus0.out_data !== 8'h55) begin n_fail++; $display("FAIL bp_next_data: got %h want 55", bus0.out_data); end
    n_cmp++; if (bus0.words_out !== 8'(w0 + 8'd1)) begin n_fail++; $display("FAIL bp_words1: got %0d want %0d", bus0.words_out, 8'(w0 + 8'd1)); end
    step(4);
    n_cmp++; if (bus0.words_out !== 8'(w0 + 8'd3)) begin n_fail++; $display("FAIL bp_words3: got %0d want %0d", bus0.words_out, 8'(w0 + 8'd3)); end
    n_cmp++; if (pop_cnt - p0 !== 6) begin n_fail++; $display("FAIL bp_pops_total: got %0d want 6", pop_cnt - p0); end
    n_cmp++; if (bus0.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained: got %b want 0", bus0.out_valid); end
  endtask

  task automatic test_empty;
    int seen;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (bus0.fifo_rd_en) seen++;
      step(1);
    end
    n_cmp++; if (seen !== 0) begin n_fail++; $display("FAIL empty_rd_en: got %0d cycles want 0", seen); end
    n_cmp++; if (bad_rd !== 0) begin n_fail++; $display("FAIL empty_read_while_empty: got %0d want 0", bad_rd); end
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0;
    push(4'h1);
    push(4'h2);
    push(4'h3);
    step(3);
    n_cmp++; if (bus0.out_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_pending: got %b want 1", bus0.out_valid); end
    rstN = 1'b0;
    #1;
    n_cmp++; if (bus0.out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid: got %b want 0", bus0.out_valid); end
    n_cmp++; if (bus0.out_data !== 8'h00) begin n_fail++; $display("FAIL rmid_data: got %h want 00", bus0.out_data); end
    n_cmp++; if (bus0.words_out !== 8'd0) begin n_fail++; $display("FAIL rmid_words: got %0d want 0", bus0.words_out); end
    step(1);
    rstN = 1'b1;
    out_ready = 1'b1;
    push(4'hC);
    push(4'hD);
    step(2);
    n_cmp++; if (bus0.out_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_new_valid: got %b want 1", bus0.out_valid); end
    n_cmp++; if (bus0.out_data !== 8'hDC) begin n_fail++; $display("FAIL rmid_new_lsb: got %h want dc", bus0.out_data); end
    n_cmp++; if (bus1.out_data !== 8'hCD) begin n_fail++; $display("FAIL rmid_new_msb: got %h want cd", bus1.out_data); end
    step(1);
    n_cmp++; if (bus0.words_out !== 8'd1) begin n_fail++; $display("FAIL rmid_words_after: got %0d want 1", bus0.words_out); end
  endtask

  task automatic test_flush;
    bit found;
    int seen;
    out_ready = 1'b1;
    push(4'h7);
`ifdef PACKER_FLUSH_TIMEOUT_EN
    found = 1'b0;
    seen = 0;
    step(17);   // pop edge plus 16 empty cycles
    n_cmp++; if (bus0.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_early: got %b want 0", bus0.out_valid); end
    for (int k = 0; k < 8 && !found; k++) begin
      step(1);
      if (bus0.out_valid) found = 1'b1;
    end
    n_cmp++; if (found !== 1'b1) begin n_fail++; $display("FAIL flush_timeout: got no word want partial word"); end
    n_cmp++; if (bus0.out_data !== 8'h07) begin n_fail++; $display("FAIL flush_lsb: got %h want 07", bus0.out_data); end
    n_cmp++; if (bus1.out_data !== 8'h70) begin n_fail++; $display("FAIL flush_msb: got %h want 70", bus1.out_data); end
    n_cmp++; if (bus0.out_partial !== 1'b1) begin n_fail++; $display("FAIL flush_partial: got %b want 1", bus0.out_partial); end
    step(1);
    n_cmp++; if (bus0.out_partial !== 1'b0) begin n_fail++; $display("FAIL flush_partial_clear: got %b want 0", bus0.out_partial); end
`else
    found = 1'b0;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      step(1);
      if (bus0.out_valid) seen++;
      if (bus0.out_partial) found = 1'b1;
    end
    n_cmp++; if (seen !== 0) begin n_fail++; $display("FAIL noflush_valid: got %0d cycles want 0", seen); end
    n_cmp++; if (found !== 1'b0) begin n_fail++; $display("FAIL noflush_partial: got 1 want 0"); end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 4'h0;
    @(negedge clk);
    test_reset;
    test_basic;
    test_back_to_back;
    test_backpressure;
    test_empty;
    test_reset_mid;
    test_flush;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_nibble_packer.md
Name: fifo_nibble_packer

Overview:
Read-side consumer that sits directly downstream of the team's 4-bit FIFO. It pops nibbles from the FIFO whenever data is present and packs NIBBLES consecutive nibbles into one output word. It presents each word on a registered valid/ready interface. It applies backpressure by withholding read_en, so the FIFO never sees a read while empty.

Parameters:
NIBBLES, 2, nibbles per output word (2..8); output width W = 4*NIBBLES
LSB_FIRST, 1, 1: first nibble popped lands in out_data[3:0]; 0: first nibble lands in out_data[W-1:W-4]
TIMEOUT, 16, idle cycles before a partial-word flush (used only with the optional feature, 1..255)

Ports:
clk  in  1  clock, rising edge
rstN  in  1  asynchronous active-low reset
fifo_empty  in  1  FIFO empty flag
fifo_rd_data  in  4  FIFO read data, valid in the same cycle as fifo_rd_en (fall-through read)
fifo_rd_en  out  1  FIFO pop request
out_data  out  W  packed word
out_valid  out  1  out_data valid
out_ready  in  1  downstream accepts the word when out_valid && out_ready
out_partial  out  1  word is a zero-padded partial flush
words_out  out  8  count of accepted words, wraps 255->0

Behaviour:
- Reset (async assert, release sync to clk): out_data=0, out_valid=0, out_partial=0, words_out=0, nib_cnt=0, accumulator=0, state=IDLE.
- fifo_rd_en is combinational: !fifo_empty && !stall, where stall = (nib_cnt==NIBBLES-1) && out_valid && !out_ready. It is never 1 while fifo_empty=1.
- On a pop, fifo_rd_data is written into the accumulator slot nib_cnt, following the LSB_FIRST ordering. nib_cnt then increments.
- On the pop that completes a word (nib_cnt==NIBBLES-1):
  - the accumulator plus the current nibble load into out_data in the same edge;
  - out_valid=1 on the next cycle;
  - nib_cnt returns to 0 and the accumulator clears.
- Latency: last nibble popped in cycle t -> out_valid high in cycle t+1.
- Throughput: with out_ready held high and the FIFO never empty, one word every NIBBLES cycles, with no bubbles.
- Handshake: out_valid stays high and out_data is held stable until out_valid && out_ready. On acceptance, out_valid drops unless a new word loads on that same edge; in that case out_valid stays 1 with the new data.
- words_out increments on each accepted word, 8-bit wrap.
- FSM states:
  - IDLE: nib_cnt==0. -> FILL on a pop, or -> IDLE if NIBBLES==1.
  - FILL: 0<nib_cnt<NIBBLES. Holds while the FIFO is empty. -> IDLE when the word completes.
  - The output register is independent of the FSM.
- Simultaneous events:
  - Completing a pop while the output is accepted in the same cycle is legal; there is no stall.
  - Completing a pop while out_valid && !out_ready is blocked by stall.
  - Non-completing pops are never stalled.
- Reset mid-word discards the partial accumulator and any pending output word.

Optional Feature:
PACKER_FLUSH_TIMEOUT_EN.

When defined:
- An 8-bit idle counter clears on every pop and whenever state==IDLE.
- In FILL, it increments each cycle that fifo_empty=1.
- When it reaches TIMEOUT and the output register is free (or is being accepted that cycle), the partial word is emitted:
  - unfilled nibble slots are 0;
  - out_partial=1 with that word;
  - nib_cnt returns to 0 and the counter clears.
- out_partial clears when that word is accepted.

When not defined:
- There is no counter, and partial words wait indefinitely.
- out_partial is tied to 0.

Test Plan:
- Reset then push 0x3,0x A into the FIFO, out_ready=1, NIBBLES=2, LSB_FIRST=1 -> out_data=0xA3 with out_valid for 1 cycle, exactly 2 cycles after the first pop; words_out=1.
- LSB_FIRST=0, same nibbles -> out_data=0x3A.
- Stream 8 nibbles 0x1..0x8 back-to-back, out_ready=1 -> words 0x21,0x43,0x65,0x87 on consecutive odd cycles; fifo_rd_en high for 8 consecutive cycles.
- Hold out_ready=0 with FIFO full of 0x5 nibbles -> first word 0x55 held; exactly one more nibble popped, then fifo_rd_en=0. Raise out_ready -> next word 0x55 arrives the cycle after acceptance with no data loss.
- fifo_empty=1 throughout -> fifo_rd_en never 1. Assert rstN=0 mid-word after 1 nibble -> all outputs 0 immediately and the next word packs from slot 0.
- PACKER_FLUSH_TIMEOUT_EN, TIMEOUT=16: pop a single 0x7, then FIFO empty -> after 16 empty cycles, out_data=0x07 with out_partial=1. Without the macro -> no output and out_partial=0.
